// File: rtl/pipe_trace_pkg.sv
// Purpose : shared types for the pipeline writeback trace buffer.
// Latency : n/a (types and constants only).
// Backpres: n/a.
// Contents: trace_state_t (IDLE/CAPTURE/POST/FROZEN), trace_entry_t {dest, data, stamp},
//           EMPTY_ENTRY, and the default field widths the entry layout is built from.
package pipe_trace_pkg;

   // Entry field widths; the buffer's DATA_W/REG_W/STAMP_W default to these.
   localparam int PT_DATA_W  = 32;
   localparam int PT_REG_W   = 5;
   localparam int PT_STAMP_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_POST    = 2'd2,
      ST_FROZEN  = 2'd3
   } trace_state_t;

   typedef struct packed {
      logic [PT_REG_W-1:0]   dest;
      logic [PT_DATA_W-1:0]  data;
      logic [PT_STAMP_W-1:0] stamp;
   } trace_entry_t;

   localparam trace_entry_t EMPTY_ENTRY = '0;

endpackage

// File: rtl/pipe_trace_buffer_ram.sv
// Purpose : DEPTH x trace_entry_t storage, one write port, one registered read port.
// Latency : read data valid the cycle after re; a same-edge write returns old contents.
// Backpres: none; accepts a read and a write every cycle.
// Ports   : clock; we/waddr/wdat write port; re/raddr read request; rdat registered read data.
module trace_ram
   import pipe_trace_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clock,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  trace_entry_t             wdat,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output trace_entry_t             rdat
);

   trace_entry_t mem [DEPTH];

   // Both updates are non-blocking, so a read of the address being written
   // on the same edge sees the previous contents.
   always_ff @(posedge clock) begin
      if (we)
         mem[waddr] <= wdat;
      if (re)
         rdat <= mem[raddr];
   end

endmodule

// File: rtl/pipe_trace_buffer.sv
// Purpose : snoops pipeline writebacks into a circular trace with trigger/freeze and perf counters.
// Latency : capture lands at the writeback edge; readout response exactly one cycle after rd_req.
// Backpres: none; observer never stalls the pipe, reads may issue every cycle.
// Ports   : clock/reset; wwreg/wdestReg/wbData/stall snoop; arm, trig_en/trig_reg control;
//           rd_req/rd_idx -> rd_valid/rd_err/rd_dest/rd_data/rd_stamp; count, state, counters.
module pipe_trace_buffer
   import pipe_trace_pkg::*;
#(
   parameter int DATA_W    = PT_DATA_W,
   parameter int REG_W     = PT_REG_W,
   parameter int DEPTH     = 16,
   parameter int STAMP_W   = PT_STAMP_W,
   parameter int CNT_W     = 32,
   parameter int STALL_W   = 2,
   parameter int POST_TRIG = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     wwreg,
   input  logic [REG_W-1:0]         wdestReg,
   input  logic [DATA_W-1:0]        wbData,
   input  logic [STALL_W-1:0]       stall,
   input  logic                     arm,
   input  logic                     trig_en,
   input  logic [REG_W-1:0]         trig_reg,
   input  logic                     rd_req,
   input  logic [$clog2(DEPTH)-1:0] rd_idx,
   output logic                     rd_valid,
   output logic                     rd_err,
   output logic [REG_W-1:0]         rd_dest,
   output logic [DATA_W-1:0]        rd_data,
   output logic [STAMP_W-1:0]       rd_stamp,
   output logic [$clog2(DEPTH):0]   count,
   output logic [1:0]               state,
   output logic [CNT_W-1:0]         cycle_cnt,
   output logic [CNT_W-1:0]         stall_cnt,
   output logic [CNT_W-1:0]         wb_cnt
);

   localparam int                IDX_W     = $clog2(DEPTH);
   localparam logic [IDX_W:0]    FULL      = (IDX_W+1)'(DEPTH);
   localparam logic [IDX_W-1:0]  POST_INIT = IDX_W'(POST_TRIG);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   trace_state_t     st;
   logic [IDX_W-1:0] wr_ptr;
   logic [IDX_W-1:0] remain;
   logic [STAMP_W-1:0] stamp;

   logic             active;
   logic             cap;
   logic             trig;
   logic [IDX_W-1:0] oldest;
   logic [IDX_W-1:0] raddr;
   logic             rd_miss;
   logic             show;
   trace_entry_t     wr_entry;
   trace_entry_t     rd_q;

   assign active = (st == ST_CAPTURE) || (st == ST_POST);
   // arm wins over a coincident writeback; r0 writes are never recorded,
   // which also makes trig_reg == 0 unmatchable.
   assign cap    = active && !arm && wwreg && (wdestReg != '0);
   assign trig   = cap && (st == ST_CAPTURE) && trig_en && (wdestReg == trig_reg);

   // Until the ring wraps the oldest entry sits at slot 0; afterwards it is
   // the slot about to be overwritten.
   assign oldest  = (count == FULL) ? wr_ptr : '0;
   assign raddr   = oldest + rd_idx;
   assign rd_miss = ({1'b0, rd_idx} >= count);

   assign wr_entry = '{dest: wdestReg, data: wbData, stamp: stamp};

   trace_ram #(.DEPTH(DEPTH)) u_ram (
      .clock (clock),
      .we    (cap),
      .waddr (wr_ptr),
      .wdat  (wr_entry),
      .re    (rd_req),
      .raddr (raddr),
      .rdat  (rd_q)
   );

   // RAM output is don't-care after reset and on misses, so it is gated here.
   assign show     = rd_valid && !rd_err;
   assign rd_dest  = show ? rd_q.dest  : '0;
   assign rd_data  = show ? rd_q.data  : '0;
   assign rd_stamp = show ? rd_q.stamp : '0;
   assign state    = st;

   always_ff @(posedge clock) begin
      if (reset) begin
         st        <= ST_IDLE;
         wr_ptr    <= '0;
         count     <= '0;
         remain    <= '0;
         stamp     <= '0;
         cycle_cnt <= '0;
         stall_cnt <= '0;
         wb_cnt    <= '0;
         rd_valid  <= 1'b0;
         rd_err    <= 1'b0;
      end else begin
         rd_valid <= rd_req;
         rd_err   <= rd_req && rd_miss;
         stamp    <= stamp + 1'b1;

         if (arm) begin
            st        <= ST_CAPTURE;
            wr_ptr    <= '0;
            count     <= '0;
            remain    <= '0;
            stamp     <= '0;
            cycle_cnt <= '0;
            stall_cnt <= '0;
            wb_cnt    <= '0;
         end else begin
            if (active) begin
               cycle_cnt <= sat_inc(cycle_cnt);
               if (stall != '0)
                  stall_cnt <= sat_inc(stall_cnt);
            end

            if (cap) begin
               wb_cnt <= sat_inc(wb_cnt);
               wr_ptr <= wr_ptr + 1'b1;
               if (count != FULL)
                  count <= count + 1'b1;
            end

            case (st)
               ST_CAPTURE: begin
                  if (trig) begin
                     if (POST_TRIG == 0) begin
                        st <= ST_FROZEN;
                     end else begin
                        st     <= ST_POST;
                        remain <= POST_INIT;
                     end
                  end
               end
               ST_POST: begin
                  // The capture that uses up the last post-trigger slot is
                  // still stored; only then does the buffer freeze.
                  if (cap) begin
                     remain <= remain - 1'b1;
                     if (remain == IDX_W'(1))
                        st <= ST_FROZEN;
                  end
               end
               ST_IDLE, ST_FROZEN: ;
               default: st <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
